crush_detector: RTL and testbench
=================================

Name: crush_detector

Overview:
- Upstream stage of the lives/hearts HUD sprite. Generates its i_crushed input.
- Watches per-pixel hit flags from the player sprite and the obstacle sprites. Counts overlapping pixels over each frame. At each frame boundary, decides whether the player was crushed.
- Emits a clean, stretched crush pulse whose rising edge the HUD consumes, then enforces an invulnerability window with a blink flag for the player sprite.
- Tracks lives lost and stops on the third crush.

Parameters:
- MIN_OVERLAP, 16, overlapping pixels needed in one frame to count as a crush.
- PULSE_CYCLES, 4, clock cycles o_crushed is held high per crush.
- INVULN_FRAMES, 90, frames after a crush during which overlap is ignored.
- BLINK_FRAMES, 8, frames per half-period of o_blink during invulnerability.
- MAX_LIVES, 3, crushes until dead.

Ports:
- i_clk  in  1  pixel clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_v_sync  in  1  vertical sync, same clock domain, active high. Rising edge marks the frame boundary.
- i_player_hit  in  1  player sprite has an opaque pixel at the current (i_x, i_y).
- i_obstacle_hit  in  1  any obstacle sprite has an opaque pixel at the current pixel.
- i_enable  in  1  game running. When low, the overlap counter is held at 0 and no new crush is issued.
- o_crushed  out  1  crush pulse, high for PULSE_CYCLES cycles.
- o_invuln  out  1  high during the invulnerability window.
- o_blink  out  1  player-hide flag, toggles during invulnerability.
- o_lives_lost  out  2  crushes taken so far, saturating at MAX_LIVES.
- o_is_dead  out  1  high once o_lives_lost reaches MAX_LIVES.

Behaviour:

Reset (asynchronous, i_rst_n low):
- All outputs go to 0.
- State goes to ARMED; all counters go to 0.
- If reset arrives mid-pulse, o_crushed drops immediately.

Frame edge:
- frame_edge = i_v_sync & ~v_sync_q, with v_sync_q registered on i_clk.
- Exactly one frame_edge per v_sync rising edge.

Overlap counter:
- 16 bits, saturating at 0xFFFF, no wrap.
- Increments on each cycle where i_player_hit & i_obstacle_hit & i_enable.
- On a frame_edge cycle, the counter is loaded with that cycle's overlap bit (0 or 1). That pixel belongs to the new frame.
- The frame total is compared against MIN_OVERLAP using the pre-load value, with >= comparison.

FSM states: ARMED, PULSE, INVULN, DEAD.
- ARMED: on frame_edge, if total >= MIN_OVERLAP and i_enable:
  - o_lives_lost increments.
  - Go to PULSE and load pulse_cnt = PULSE_CYCLES-1.
  - o_crushed goes high on the following cycle (1-cycle latency from frame_edge).
- PULSE:
  - o_crushed = 1; pulse_cnt decrements.
  - At 0: if o_lives_lost == MAX_LIVES go to DEAD, else go to INVULN with frame_cnt = INVULN_FRAMES.
  - frame_edges during PULSE decrement frame_cnt only after entry to INVULN; overlap during PULSE is ignored.
- INVULN:
  - o_invuln = 1.
  - Each frame_edge decrements frame_cnt and advances blink_cnt. o_blink toggles each time blink_cnt reaches BLINK_FRAMES, then blink_cnt resets.
  - At frame_cnt == 0: go to ARMED with o_blink = 0 and o_invuln = 0.
  - Overlap totals are never evaluated in INVULN. The frame_edge that ends INVULN does not trigger a crush.
- DEAD:
  - o_is_dead = 1. o_crushed, o_invuln, o_blink = 0.
  - Terminal until reset.

Output and width rules:
- o_crushed is registered, glitch-free, and at least 2 cycles wide, so the HUD's edge-triggered logic sees exactly one rising edge per crush.
- o_lives_lost never exceeds MAX_LIVES.
- i_enable low during PULSE or INVULN does not abort those states.

Decomposition:
- Shared package (game_pkg): the state enum type crush_state_t (ARMED/PULSE/INVULN/DEAD), and constants for lives count and default timing, so the HUD and game control agree on MAX_LIVES.
- One natural sub-module: edge_detect (registered rising-edge detector), reused for v_sync in other game blocks.
- Counters and FSM stay inline.

Test Plan:
- 20 overlapping pixels in frame 1, then v_sync rise → o_crushed high exactly 4 cycles starting 1 cycle after frame_edge; o_lives_lost=1; o_invuln=1 after the pulse.
- 15 overlapping pixels (MIN_OVERLAP-1) → no pulse, o_lives_lost stays 0. Next frame with exactly 16 → pulse issued.
- Crush, then 100 overlapping pixels every frame for 89 frames → no second pulse. o_blink toggles at frames 8, 16, …. Frame 91 with 16 overlaps → second pulse, o_lives_lost=2.
- Three spaced crushes → after the third pulse ends, o_is_dead=1, o_lives_lost=3. Further overlaps → no pulse.
- Overlap asserted on the frame_edge cycle itself with the prior-frame total = 15 → no crush; the new frame counter starts at 1.
- i_rst_n pulled low on the 2nd cycle of a pulse → o_crushed=0 and all outputs 0 asynchronously. After release, the state is ARMED and o_lives_lost=0.

Source files
------------

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game state type and timing constants
package game_pkg;

    // Crush FSM states shared by the HUD and game control
    typedef enum logic [1:0] {
        ST_ARMED  = 2'd0,
        ST_PULSE  = 2'd1,
        ST_INVULN = 2'd2,
        ST_DEAD   = 2'd3
    } crush_state_t;

    // Lives count; every block that tracks lives agrees on this value
    localparam int unsigned GAME_MAX_LIVES = 3;

    // Default crush timing
    localparam int unsigned GAME_MIN_OVERLAP   = 16;
    localparam int unsigned GAME_PULSE_CYCLES  = 4;
    localparam int unsigned GAME_INVULN_FRAMES = 90;
    localparam int unsigned GAME_BLINK_FRAMES  = 8;

    // Saturating 16-bit increment used by pixel counters
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - registered rising-edge detector
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic rise
);

    logic sig_q;

    // Hold the previous sample so a level change shows up as a one-cycle rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign rise = sig & ~sig_q;

endmodule

// File: rtl/crush_detector.sv
// rtl/crush_detector.sv - per-frame player/obstacle overlap crush detector
module crush_detector
    import game_pkg::*;
#(
    parameter int unsigned MIN_OVERLAP   = GAME_MIN_OVERLAP,
    parameter int unsigned PULSE_CYCLES  = GAME_PULSE_CYCLES,
    parameter int unsigned INVULN_FRAMES = GAME_INVULN_FRAMES,
    parameter int unsigned BLINK_FRAMES  = GAME_BLINK_FRAMES,
    parameter int unsigned MAX_LIVES     = GAME_MAX_LIVES
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_v_sync,
    input  logic       i_player_hit,
    input  logic       i_obstacle_hit,
    input  logic       i_enable,
    output logic       o_crushed,
    output logic       o_invuln,
    output logic       o_blink,
    output logic [1:0] o_lives_lost,
    output logic       o_is_dead
);

    logic         frame_edge;
    logic         overlap;
    logic         crush_hit;
    logic [15:0]  overlap_cnt;

    crush_state_t state;
    crush_state_t state_next;
    logic [7:0]   pulse_cnt;
    logic [7:0]   pulse_cnt_next;
    logic [15:0]  frame_cnt;
    logic [15:0]  frame_cnt_next;
    logic [15:0]  blink_cnt;
    logic [15:0]  blink_cnt_next;
    logic         blink_next;
    logic [1:0]   lives_next;

    edge_detect u_vsync_edge (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .sig   (i_v_sync),
        .rise  (frame_edge)
    );

    assign overlap   = i_player_hit & i_obstacle_hit & i_enable;
    // The total seen here is the finished frame; the edge-cycle pixel goes to the next frame
    assign crush_hit = frame_edge & i_enable & (overlap_cnt >= 16'(MIN_OVERLAP));

    // Per-frame overlap counter: restarts on each frame edge, held at zero while disabled
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            overlap_cnt <= 16'd0;
        end else if (frame_edge) begin
            overlap_cnt <= {15'd0, overlap};
        end else if (!i_enable) begin
            overlap_cnt <= 16'd0;
        end else if (overlap) begin
            overlap_cnt <= sat_inc16(overlap_cnt);
        end
    end

    // Next-state and next-counter logic for the crush FSM
    always_comb begin
        state_next     = state;
        pulse_cnt_next = pulse_cnt;
        frame_cnt_next = frame_cnt;
        blink_cnt_next = blink_cnt;
        blink_next     = o_blink;
        lives_next     = o_lives_lost;

        case (state)
            ST_ARMED: begin
                blink_next = 1'b0;
                if (crush_hit) begin
                    state_next     = ST_PULSE;
                    pulse_cnt_next = 8'(PULSE_CYCLES - 1);
                    if (o_lives_lost != 2'(MAX_LIVES)) begin
                        lives_next = o_lives_lost + 2'd1;
                    end
                end
            end

            ST_PULSE: begin
                // Overlap and frame edges are deliberately ignored while the pulse runs
                if (pulse_cnt == 8'd0) begin
                    if (o_lives_lost == 2'(MAX_LIVES)) begin
                        state_next = ST_DEAD;
                    end else begin
                        state_next     = ST_INVULN;
                        frame_cnt_next = 16'(INVULN_FRAMES);
                        blink_cnt_next = 16'd0;
                        blink_next     = 1'b0;
                    end
                end else begin
                    pulse_cnt_next = pulse_cnt - 8'd1;
                end
            end

            ST_INVULN: begin
                if (frame_cnt == 16'd0) begin
                    state_next = ST_ARMED;
                    blink_next = 1'b0;
                end else if (frame_edge) begin
                    frame_cnt_next = frame_cnt - 16'd1;
                    if (frame_cnt == 16'd1) begin
                        // Last invulnerable frame: re-arm without evaluating this edge
                        state_next     = ST_ARMED;
                        blink_next     = 1'b0;
                        blink_cnt_next = 16'd0;
                    end else if (blink_cnt == 16'(BLINK_FRAMES - 1)) begin
                        blink_cnt_next = 16'd0;
                        blink_next     = ~o_blink;
                    end else begin
                        blink_cnt_next = blink_cnt + 16'd1;
                    end
                end
            end

            ST_DEAD: begin
                blink_next = 1'b0;
            end

            default: begin
                state_next = ST_ARMED;
                blink_next = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_ARMED;
            pulse_cnt    <= 8'd0;
            frame_cnt    <= 16'd0;
            blink_cnt    <= 16'd0;
            o_crushed    <= 1'b0;
            o_invuln     <= 1'b0;
            o_blink      <= 1'b0;
            o_lives_lost <= 2'd0;
            o_is_dead    <= 1'b0;
        end else begin
            state        <= state_next;
            pulse_cnt    <= pulse_cnt_next;
            frame_cnt    <= frame_cnt_next;
            blink_cnt    <= blink_cnt_next;
            o_crushed    <= (state_next == ST_PULSE);
            o_invuln     <= (state_next == ST_INVULN);
            o_blink      <= blink_next & (state_next == ST_INVULN);
            o_lives_lost <= lives_next;
            o_is_dead    <= (state_next == ST_DEAD);
        end
    end

endmodule

// File: tb/tb_crush_detector.sv
// tb/tb_crush_detector.sv - scoreboard bench for crush_detector
module tb_crush_detector;

    localparam int MIN_OV     = 16;
    localparam int PULSE_LEN  = 4;
    localparam int INV_FRAMES = 90;
    localparam int BLINK_LEN  = 8;
    localparam int LIVES      = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       v_sync = 1'b0;
    logic       player_hit = 1'b0;
    logic       obstacle_hit = 1'b0;
    logic       enable = 1'b0;
    logic       crushed;
    logic       invuln;
    logic       blink;
    logic [1:0] lives_lost;
    logic       is_dead;

    crush_detector dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_v_sync       (v_sync),
        .i_player_hit   (player_hit),
        .i_obstacle_hit (obstacle_hit),
        .i_enable       (enable),
        .o_crushed      (crushed),
        .o_invuln       (invuln),
        .o_blink        (blink),
        .o_lives_lost   (lives_lost),
        .o_is_dead      (is_dead)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    int checks = 0;
    int errors = 0;

    typedef struct {
        int     lives;
        bit     dead;
        longint rise_cyc;
    } exp_t;

    exp_t exp_q[$];

    // Frame-level reference model
    int m_total;
    int m_lives;
    int m_inv_left;
    int m_inv_k;
    bit m_dead;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        m_total    = 0;
        m_lives    = 0;
        m_inv_left = 0;
        m_inv_k    = 0;
        m_dead     = 0;
        exp_q.delete();
    endtask

    // Called as the frame edge is driven: judge the finished frame, start the new one
    task automatic model_edge(input bit en_now, input bit edge_bit);
        exp_t e;
        if (!m_dead) begin
            if (m_inv_left > 0) begin
                m_inv_left--;
                m_inv_k++;
            end else if (m_total >= MIN_OV && en_now) begin
                m_lives++;
                e.lives    = m_lives;
                e.dead     = (m_lives == LIVES);
                e.rise_cyc = cyc + 1;
                exp_q.push_back(e);
                if (e.dead) begin
                    m_dead = 1;
                end else begin
                    m_inv_left = INV_FRAMES;
                    m_inv_k    = 0;
                end
            end
        end
        m_total = (en_now && edge_bit) ? 1 : 0;
    endtask

    task automatic check_state;
        bit inv;
        inv = !m_dead && (m_inv_left > 0);
        chk("lives_lost", lives_lost, m_lives);
        chk("is_dead", is_dead, m_dead);
        chk("invuln", invuln, inv);
        chk("blink", blink, inv && (((m_inv_k / BLINK_LEN) % 2) == 1));
        chk("crushed_idle", crushed, 0);
    endtask

    // One video frame: 2-cycle v_sync, then a body with exactly body_ov overlapping pixels
    task automatic run_frame(input bit edge_bit, input int body_ov, input bit en);
        int body_len;
        int left;
        int slots;
        body_len = (body_ov + 12 > 30) ? body_ov + 12 : 30;
        enable       = en;
        v_sync       = 1'b1;
        player_hit   = edge_bit;
        obstacle_hit = edge_bit;
        model_edge(en, edge_bit);
        step;
        player_hit   = 1'b0;
        obstacle_hit = 1'b0;
        step;
        v_sync = 1'b0;
        left = body_ov;
        for (int i = 0; i < body_len; i++) begin
            slots = body_len - i;
            if (i == 10) check_state;
            if (left > 0 && int'($urandom_range(slots - 1)) < left) begin
                player_hit   = 1'b1;
                obstacle_hit = 1'b1;
                left--;
                if (en) m_total++;
            end else begin
                case ($urandom_range(2))
                    0: begin player_hit = 1'b1; obstacle_hit = 1'b0; end
                    1: begin player_hit = 1'b0; obstacle_hit = 1'b1; end
                    default: begin player_hit = 1'b0; obstacle_hit = 1'b0; end
                endcase
            end
            step;
        end
        player_hit   = 1'b0;
        obstacle_hit = 1'b0;
    endtask

    // Monitor: every rising edge of o_crushed must match a queued crush
    initial begin
        bit   prev;
        bit   active;
        int   width;
        exp_t cur;
        prev   = 0;
        active = 0;
        width  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev   = 0;
                active = 0;
            end else begin
                if (crushed && !prev) begin
                    chk("pulse_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        cur    = exp_q.pop_front();
                        active = 1;
                        chk("pulse_latency", cyc, cur.rise_cyc);
                        chk("lives_at_pulse", lives_lost, cur.lives);
                    end
                    width = 1;
                end else if (crushed) begin
                    width++;
                end else if (prev) begin
                    chk("pulse_width", width, PULSE_LEN);
                    if (active) begin
                        chk("post_pulse_dead", is_dead, cur.dead);
                        chk("post_pulse_invuln", invuln, !cur.dead);
                    end
                    active = 0;
                end
                prev = crushed;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        rst_n = 1'b0;
        repeat (3) step;
        chk("reset_crushed", crushed, 0);
        chk("reset_invuln", invuln, 0);
        chk("reset_blink", blink, 0);
        chk("reset_lives", lives_lost, 0);
        chk("reset_dead", is_dead, 0);
        rst_n  = 1'b1;
        enable = 1'b1;
        repeat (3) step;

        // First crush followed by heavy overlap during the whole window
        run_frame(0, 0, 1);
        run_frame(0, 20, 1);
        for (int i = 0; i < 90; i++) run_frame(0, 100, 1);
        // One short of threshold, then threshold reached with the edge-cycle pixel
        run_frame(0, 15, 1);
        run_frame(1, 15, 1);
        run_frame(0, 0, 1);
        // Random traffic and enable drops inside the second window
        for (int i = 0; i < 89; i++)
            run_frame(1'($urandom_range(1)), int'($urandom_range(40)), $urandom_range(6) != 0);
        run_frame(0, 0, 1);
        run_frame(0, 16, 1);
        run_frame(0, 0, 0);
        run_frame(0, 16, 1);
        run_frame(0, 0, 1);
        for (int i = 0; i < 4; i++) run_frame(0, 50, 1);

        // Reset in the middle of a pulse
        rst_n = 1'b0;
        step;
        rst_n = 1'b1;
        model_reset();
        repeat (2) step;
        run_frame(0, 0, 1);
        run_frame(0, 20, 1);
        enable = 1'b1;
        v_sync = 1'b1;
        model_edge(1, 0);
        step;
        step;
        chk("pulse_before_reset", crushed, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_crushed", crushed, 0);
        chk("async_invuln", invuln, 0);
        chk("async_blink", blink, 0);
        chk("async_lives", lives_lost, 0);
        chk("async_dead", is_dead, 0);
        step;
        step;
        v_sync = 1'b0;
        rst_n  = 1'b1;
        model_reset();
        repeat (3) step;
        check_state;

        // Randomised frames around the threshold
        for (int i = 0; i < 220; i++)
            run_frame(1'($urandom_range(1)), int'($urandom_range(24)), $urandom_range(9) != 0);
        run_frame(0, 0, 1);

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) step;
        chk("scoreboard_drained", exp_q.size(), 0);
        repeat (10) step;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
